filter_buffer_3d_db: RTL and testbench

Double-buffered, multi-channel filter weight store for the CFA datapath: it generalises the K×K per-channel filter buffer to NUM_CH channels, generates row/column/channel addressing internally, and uses a ready/valid load handshake. Two banks let the convolution engine read a complete filter set from one bank while the next set streams into the other. It sits between the weight loader and the multiply-accumulate array.

---
 rtl/filter_buffer_3d_db.sv | 120 ++++++++++++
 tb/tb_filter_buffer_3d_db.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_buffer_3d_db.sv
`default_nettype none
// ============================================================================
// Module   : filter_buffer_3d_db
// Purpose  : Double-buffered NUM_CH x K x K filter weight store with a
//            ready/valid load port and full-set parallel read-out.
// Revision : 1.0
// ============================================================================
module filter_buffer_3d_db #(
    parameter int FILTER_SIZE = 3,
    parameter int FILTER_BW   = 8,
    parameter int NUM_CH      = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            clear,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [FILTER_BW-1:0]                            d_in,
    // "release" is a reserved word, hence the prefix.
    input  logic                                            buf_release,
    output logic                                            filter_valid,
    output logic [NUM_CH*FILTER_SIZE*FILTER_SIZE*FILTER_BW-1:0] filter_data,
    output logic                                            load_done
);

    localparam int SET_WORDS = NUM_CH * FILTER_SIZE * FILTER_SIZE;
    localparam int IDX_W     = $clog2(SET_WORDS);
    localparam int K_W       = $clog2(FILTER_SIZE);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [K_W-1:0]   c_k_last  = K_W'(FILTER_SIZE - 1);
    localparam logic [CH_W-1:0]  c_ch_last = CH_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] c_k       = IDX_W'(FILTER_SIZE);
    localparam logic [IDX_W-1:0] c_kk      = IDX_W'(FILTER_SIZE * FILTER_SIZE);

    logic [FILTER_BW-1:0] r_bank [2][SET_WORDS];
    logic [1:0]           r_full;
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic [K_W-1:0]       r_col;
    logic [K_W-1:0]       r_row;
    logic [CH_W-1:0]      r_ch;
    logic                 r_load_done;

    logic                 w_accept;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_ch_last;
    logic                 w_last;
    logic                 w_rel;
    logic [IDX_W-1:0]     w_elem;

    assign in_ready   = !rst && !r_full[r_wr_bank];
    assign w_accept   = in_valid && in_ready;
    assign w_col_last = (r_col == c_k_last);
    assign w_row_last = (r_row == c_k_last);
    assign w_ch_last  = (r_ch == c_ch_last);
    assign w_last     = w_accept && w_col_last && w_row_last && w_ch_last;
    // A release is only meaningful while the read bank holds a set.
    assign w_rel      = buf_release && r_full[r_rd_bank];
    assign w_elem     = IDX_W'(r_ch) * c_kk + IDX_W'(r_row) * c_k + IDX_W'(r_col);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_full      <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_ch        <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_last;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row <= '0;
                        r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // When both fire they address different banks, so the two updates never collide.
            if (w_last) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_rel) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < SET_WORDS; e++) begin
                    r_bank[b][e] <= '0;
                end
            end
        end else if (w_accept && !clear) begin
            r_bank[r_wr_bank][w_elem] <= d_in;
        end
    end

    assign filter_valid = r_full[r_rd_bank];
    assign load_done    = r_load_done;

    for (genvar e = 0; e < SET_WORDS; e++) begin : g_elem
        assign filter_data[e*FILTER_BW +: FILTER_BW] =
            filter_valid ? r_bank[r_rd_bank][e] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_buffer_3d_db.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_buffer_3d_db
// Purpose  : Scoreboard bench for filter_buffer_3d_db (K=3, BW=8, NUM_CH=2).
// Revision : 1.0
// ============================================================================
module tb_filter_buffer_3d_db;

    localparam int K  = 3;
    localparam int BW = 8;
    localparam int NC = 2;
    localparam int SW = NC * K * K;
    localparam int OW = SW * BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] d_in = '0;
    logic          buf_release = 1'b0;
    logic          filter_valid;
    logic [OW-1:0] filter_data;
    logic          load_done;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_sets = 0;
    int            n_done_pulses = 0;
    int            stall_cnt = 0;
    logic [BW-1:0] set_buf [SW];
    logic [OW-1:0] exp_q [$];

    filter_buffer_3d_db #(
        .FILTER_SIZE(K),
        .FILTER_BW  (BW),
        .NUM_CH     (NC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .d_in        (d_in),
        .buf_release (buf_release),
        .filter_valid(filter_valid),
        .filter_data (filter_data),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!rst && load_done) n_done_pulses++;

    task automatic check_val(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word, optionally after random idle cycles; returns just after the accepting edge.
    task automatic push_word(input logic [BW-1:0] v, input int duty, input bit noise, input bit rel);
        int guard = 0;
        while (duty < 100 && $urandom_range(99) >= duty && guard < 50) begin
            in_valid    = 1'b0;
            buf_release = noise ? 1'($urandom_range(1)) : 1'b0;
            step();
            guard++;
        end
        in_valid    = 1'b1;
        d_in        = v;
        buf_release = noise ? 1'($urandom_range(1)) : rel;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            stall_cnt++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check_val("push_timeout", OW'(in_ready), OW'(1));
        step();
        buf_release = 1'b0;
    endtask

    task automatic load_set(input string tag, input int duty, input bit noise,
                            input bit rel_last, input bit pre_valid);
        logic [OW-1:0] v;
        stall_cnt = 0;
        for (int e = 0; e < SW; e++) begin
            if (e == SW - 1) begin
                in_valid = 1'b0;
                @(negedge clk);
                check_val({tag, "_pre_valid"}, OW'(filter_valid), OW'(pre_valid));
                step();
            end
            push_word(set_buf[e], duty, noise, rel_last && (e == SW - 1));
        end
        in_valid = 1'b0;
        v = '0;
        for (int e = 0; e < SW; e++) v[e*BW +: BW] = set_buf[e];
        if (rel_last && exp_q.size() > 0) void'(exp_q.pop_front());
        exp_q.push_back(v);
        n_sets++;
        @(negedge clk);
        check_val({tag, "_load_done"}, OW'(load_done), OW'(1));
        check_val({tag, "_valid"}, OW'(filter_valid), OW'(1));
        check_val({tag, "_data"}, filter_data, exp_q[0]);
        step();
        @(negedge clk);
        check_val({tag, "_done_1shot"}, OW'(load_done), OW'(0));
        step();
    endtask

    task automatic release_set(input string tag);
        buf_release = 1'b1;
        step();
        buf_release = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        if (exp_q.size() > 0) begin
            check_val({tag, "_valid"}, OW'(filter_valid), OW'(1));
            check_val({tag, "_data"}, filter_data, exp_q[0]);
        end else begin
            check_val({tag, "_valid"}, OW'(filter_valid), OW'(0));
            check_val({tag, "_data"}, filter_data, '0);
        end
        check_val({tag, "_ready"}, OW'(in_ready), OW'(1));
        step();
    endtask

    task automatic fill_ramp(input int base);
        for (int e = 0; e < SW; e++) set_buf[e] = BW'(base + e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", OW'(in_ready), OW'(0));
        check_val("rst_valid", OW'(filter_valid), OW'(0));
        check_val("rst_data", filter_data, '0);
        check_val("rst_done", OW'(load_done), OW'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", OW'(in_ready), OW'(1));
        step();

        // Back-to-back ramp 0..17.
        fill_ramp(0);
        load_set("ramp", 100, 1'b0, 1'b0, 1'b0);
        check_val("ramp_no_stall", OW'(stall_cnt), OW'(0));
        release_set("ramp_rel");

        // Two sets without release: input must stall, A stays visible.
        fill_ramp(1);
        load_set("setA", 100, 1'b0, 1'b0, 1'b0);
        fill_ramp(101);
        load_set("setB", 100, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_val("both_full_ready", OW'(in_ready), OW'(0));
        check_val("both_full_data", filter_data, exp_q[0]);
        step();
        release_set("relA");
        release_set("relB");

        // Release on the same edge as the last word of the second set.
        fill_ramp(1);
        load_set("setA2", 100, 1'b0, 1'b0, 1'b0);
        fill_ramp(101);
        load_set("setB2_rel", 100, 1'b0, 1'b1, 1'b1);
        release_set("relB2");

        // Negative weights at both ends of the set.
        fill_ramp(0);
        set_buf[0]      = 8'hFF;
        set_buf[SW - 1] = 8'h80;
        load_set("neg", 100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("neg_lo", OW'(filter_data[7:0]), OW'(8'hFF));
        check_val("neg_hi", OW'(filter_data[OW-1 -: BW]), OW'(8'h80));
        step();
        release_set("neg_rel");

        // Partial load discarded by clear.
        fill_ramp(200);
        for (int e = 0; e < 7; e++) push_word(set_buf[e], 100, 1'b0, 1'b0);
        in_valid = 1'b0;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        check_val("clr_valid", OW'(filter_valid), OW'(0));
        check_val("clr_ready", OW'(in_ready), OW'(1));
        step();
        fill_ramp(0);
        load_set("post_clr", 100, 1'b0, 1'b0, 1'b0);
        release_set("post_clr_rel");

        // Sparse input with spurious releases while nothing is valid.
        fill_ramp(50);
        load_set("sparse", 30, 1'b1, 1'b0, 1'b0);
        release_set("sparse_rel");

        check_val("done_pulses", OW'(n_done_pulses), OW'(n_sets));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
